multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the MIPS datapath. It replaces the single-cycle decoder with a registered IF/ID/EX/MEM/WB sequencer.

---
 rtl/multicycle_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: registered IF/ID/EX/MEM/WB control sequencer for the MIPS
// datapath. Decodes addu/add/subu/sub, ori, lw, sw, beq, bne, lui, slti and j,
// handshakes with instruction and data memory, times out stalled accesses and
// parks in a sticky error state until reset.
module multicycle_ctrl #(
    parameter int unsigned ALUCTRL_W = 5,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 imem_rdy,
    input  logic                 dmem_rdy,
    output logic                 imem_req,
    output logic                 ir_wr,
    output logic                 pc_wr,
    output logic [1:0]           pc_src,
    output logic                 reg_w,
    output logic                 reg_dst,
    output logic                 alu_src,
    output logic [1:0]           ext_op,
    output logic [ALUCTRL_W-1:0] aluctrl,
    output logic                 mem_r,
    output logic                 mem_w,
    output logic                 mem2r,
    output logic [1:0]           err,
    output logic [2:0]           state
);

    // ALU operation codes shared with the ALU
    localparam logic [ALUCTRL_W-1:0] ALU_NOP  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_ADDU = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_SUBU = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(6);

    // Immediate extender modes
    localparam logic [1:0] EXT_ZERO    = 2'b00;
    localparam logic [1:0] EXT_SIGNED  = 2'b01;
    localparam logic [1:0] EXT_HIGHPOS = 2'b10;

    // PC source selects
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Sticky error codes
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Opcodes and R-type function codes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;

    // Wait counter only has to reach TIMEOUT-1: the stall that would make it
    // TIMEOUT is the one that raises the error instead.
    localparam int unsigned       CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        I_ILL,
        I_ADDU,
        I_ADD,
        I_SUBU,
        I_SUB,
        I_ORI,
        I_LUI,
        I_SLTI,
        I_LW,
        I_SW,
        I_BEQ,
        I_BNE,
        I_J
    } instr_e;

    state_e           cur_state;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] wait_cnt;
    logic [5:0]       op_lat;
    logic [5:0]       fn_lat;

    instr_e           id_instr;
    instr_e           ex_instr;
    logic             timed_out;
    logic             ex_rtype;

    logic [ALUCTRL_W-1:0] ex_alu;
    logic                 ex_src;
    logic [1:0]           ex_ext;

    function automatic instr_e decode(input logic [5:0] op, input logic [5:0] fn);
        instr_e r;
        r = I_ILL;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU: r = I_ADDU;
                    FN_ADD:  r = I_ADD;
                    FN_SUBU: r = I_SUBU;
                    FN_SUB:  r = I_SUB;
                    default: r = I_ILL;
                endcase
            end
            OP_ORI:  r = I_ORI;
            OP_LUI:  r = I_LUI;
            OP_SLTI: r = I_SLTI;
            OP_LW:   r = I_LW;
            OP_SW:   r = I_SW;
            OP_BEQ:  r = I_BEQ;
            OP_BNE:  r = I_BNE;
            OP_J:    r = I_J;
            default: r = I_ILL;
        endcase
        return r;
    endfunction

    // ID decodes the live IR; later states use the copy latched in ID
    assign id_instr  = decode(opcode, funct);
    assign ex_instr  = decode(op_lat, fn_lat);
    assign ex_rtype  = (ex_instr == I_ADDU) || (ex_instr == I_ADD) ||
                       (ex_instr == I_SUBU) || (ex_instr == I_SUB);
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    assign state = cur_state;
    assign err   = err_code;

    // Sequencer: state, sticky error, wait counter and latched instruction fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IF;
            err_code  <= ERR_NONE;
            wait_cnt  <= '0;
            op_lat    <= '0;
            fn_lat    <= '0;
        end else begin
            case (cur_state)
                S_IF: begin
                    if (imem_rdy) begin
                        cur_state <= S_ID;
                        wait_cnt  <= '0;
                    end else if (timed_out) begin
                        cur_state <= S_ERR;
                        err_code  <= ERR_TIMEOUT;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ID: begin
                    op_lat   <= opcode;
                    fn_lat   <= funct;
                    wait_cnt <= '0;
                    case (id_instr)
                        I_ILL: begin
                            cur_state <= S_ERR;
                            err_code  <= ERR_ILLEGAL;
                        end
                        I_J:     cur_state <= S_IF;
                        default: cur_state <= S_EX;
                    endcase
                end
                S_EX: begin
                    wait_cnt <= '0;
                    case (ex_instr)
                        I_LW, I_SW:   cur_state <= S_MEM;
                        I_BEQ, I_BNE: cur_state <= S_IF;
                        default:      cur_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_rdy) begin
                        cur_state <= (ex_instr == I_LW) ? S_WB : S_IF;
                        wait_cnt  <= '0;
                    end else if (timed_out) begin
                        cur_state <= S_ERR;
                        err_code  <= ERR_TIMEOUT;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    cur_state <= S_IF;
                    wait_cnt  <= '0;
                end
                S_ERR: begin
                    wait_cnt <= '0;
                end
                default: begin
                    cur_state <= S_IF;
                    wait_cnt  <= '0;
                end
            endcase
        end
    end

    // ALU/extender setup for the latched instruction, shared by EX and MEM
    always_comb begin
        ex_alu = ALU_NOP;
        ex_src = 1'b0;
        ex_ext = EXT_ZERO;
        case (ex_instr)
            I_ADDU: ex_alu = ALU_ADDU;
            I_ADD:  ex_alu = ALU_ADD;
            I_SUBU: ex_alu = ALU_SUBU;
            I_SUB:  ex_alu = ALU_SUB;
            I_ORI: begin
                ex_alu = ALU_OR;
                ex_src = 1'b1;
                ex_ext = EXT_ZERO;
            end
            I_LUI: begin
                ex_alu = ALU_OR;
                ex_src = 1'b1;
                ex_ext = EXT_HIGHPOS;
            end
            I_SLTI: begin
                ex_alu = ALU_SLT;
                ex_src = 1'b1;
                ex_ext = EXT_SIGNED;
            end
            I_LW, I_SW: begin
                ex_alu = ALU_ADD;
                ex_src = 1'b1;
                ex_ext = EXT_SIGNED;
            end
            I_BEQ, I_BNE: begin
                ex_alu = ALU_SUB;
                ex_src = 1'b0;
                ex_ext = EXT_SIGNED;
            end
            default: begin
                ex_alu = ALU_NOP;
                ex_src = 1'b0;
                ex_ext = EXT_ZERO;
            end
        endcase
    end

    // Datapath controls decoded from state; everything is forced low while in reset
    always_comb begin
        imem_req = 1'b0;
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        pc_src   = PC_PLUS4;
        reg_w    = 1'b0;
        reg_dst  = 1'b0;
        alu_src  = 1'b0;
        ext_op   = EXT_ZERO;
        aluctrl  = ALU_NOP;
        mem_r    = 1'b0;
        mem_w    = 1'b0;
        mem2r    = 1'b0;
        case (cur_state)
            S_IF: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    ir_wr  = 1'b1;
                    pc_wr  = 1'b1;
                    pc_src = PC_PLUS4;
                end
            end
            S_ID: begin
                if (id_instr == I_J) begin
                    pc_wr  = 1'b1;
                    pc_src = PC_JUMP;
                end
            end
            S_EX: begin
                aluctrl = ex_alu;
                alu_src = ex_src;
                ext_op  = ex_ext;
                if (ex_instr == I_BEQ) begin
                    pc_src = PC_BRANCH;
                    pc_wr  = zero;
                end else if (ex_instr == I_BNE) begin
                    pc_src = PC_BRANCH;
                    pc_wr  = ~zero;
                end
            end
            S_MEM: begin
                aluctrl = ex_alu;
                alu_src = ex_src;
                ext_op  = ex_ext;
                mem_r   = (ex_instr == I_LW);
                mem_w   = (ex_instr == I_SW);
            end
            S_WB: begin
                reg_w   = 1'b1;
                reg_dst = ~ex_rtype;
                mem2r   = (ex_instr == I_LW);
            end
            default: ;
        endcase
        // imem_req is high in IF, which is also the reset state, so gate it explicitly
        if (!rst_n) begin
            imem_req = 1'b0;
            ir_wr    = 1'b0;
            pc_wr    = 1'b0;
            pc_src   = PC_PLUS4;
            reg_w    = 1'b0;
            reg_dst  = 1'b0;
            alu_src  = 1'b0;
            ext_op   = EXT_ZERO;
            aluctrl  = ALU_NOP;
            mem_r    = 1'b0;
            mem_w    = 1'b0;
            mem2r    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for multicycle_ctrl. Inputs change
// just after the falling edge; outputs are compared 1 ns later, in the middle
// of the low phase, against hand-built control words.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       imem_rdy = 1'b0;
    logic       dmem_rdy = 1'b0;

    logic       imem_req, ir_wr, pc_wr, reg_w, reg_dst, alu_src, mem_r, mem_w, mem2r;
    logic [1:0] pc_src, ext_op, err;
    logic [4:0] aluctrl;
    logic [2:0] state;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ALUCTRL_W(5), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .imem_req(imem_req), .ir_wr(ir_wr),
        .pc_wr(pc_wr), .pc_src(pc_src), .reg_w(reg_w), .reg_dst(reg_dst),
        .alu_src(alu_src), .ext_op(ext_op), .aluctrl(aluctrl), .mem_r(mem_r),
        .mem_w(mem_w), .mem2r(mem2r), .err(err), .state(state)
    );

    // Instruction fields
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_SLTI = 6'h0A, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_BAD = 6'h3F;
    localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;

    // ALU and extender codes
    localparam logic [4:0] A_ADDU = 5'd1, A_ADD = 5'd2, A_SUBU = 5'd3, A_SUB = 5'd4;
    localparam logic [4:0] A_OR = 5'd5, A_SLT = 5'd6;
    localparam logic [1:0] E_ZERO = 2'd0, E_SIGNED = 2'd1, E_HIGHPOS = 2'd2;

    // Control word: req irw pcw pcs[2] rw rdst asrc ext[2] alu[5] mr mw m2r err[2]
    localparam logic [19:0] REQ  = 20'h80000;
    localparam logic [19:0] IRW  = 20'h40000;
    localparam logic [19:0] PCW  = 20'h20000;
    localparam logic [19:0] RW   = 20'h04000;
    localparam logic [19:0] RDST = 20'h02000;
    localparam logic [19:0] ASRC = 20'h01000;
    localparam logic [19:0] MR   = 20'h00010;
    localparam logic [19:0] MW   = 20'h00008;
    localparam logic [19:0] M2R  = 20'h00004;
    localparam logic [19:0] FETCH = REQ | IRW | PCW;

    function automatic logic [19:0] w_pcs(input logic [1:0] v); return {3'b0, v, 15'b0}; endfunction
    function automatic logic [19:0] w_ext(input logic [1:0] v); return {8'b0, v, 10'b0}; endfunction
    function automatic logic [19:0] w_alu(input logic [4:0] v); return {10'b0, v, 5'b0}; endfunction
    function automatic logic [19:0] w_err(input logic [1:0] v); return {18'b0, v}; endfunction

    logic [19:0] dut_word;
    assign dut_word = {imem_req, ir_wr, pc_wr, pc_src, reg_w, reg_dst, alu_src,
                       ext_op, aluctrl, mem_r, mem_w, mem2r, err};

    localparam logic [19:0] MEM_ADDR = ASRC | w_ext(E_SIGNED) | w_alu(A_ADD);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One cycle: check state and control word, then advance to the next falling edge
    task automatic cyc(input string tag, input logic [2:0] st, input logic [19:0] w);
        #1;
        check({tag, "/state"}, 32'(state), 32'(st));
        check({tag, "/ctl"}, 32'(dut_word), 32'(w));
        @(negedge clk);
    endtask

    // Reset pulse spanning a rising edge; released just after a rising edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        #1;
        check({tag, "/rst state"}, 32'(state), 32'd0);
        check({tag, "/rst ctl"}, 32'(dut_word), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "/rst held ctl"}, 32'(dut_word), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check({tag, "/post-rst state"}, 32'(state), 32'd0);
        check({tag, "/post-rst ctl"}, 32'(dut_word), 32'(REQ));
        @(negedge clk);
    endtask

    // Fetch with zero wait followed by a non-jump decode
    task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct = fn;
        imem_rdy = 1'b1;
        cyc({tag, " IF"}, 3'd0, FETCH);
        imem_rdy = 1'b0;
        cyc({tag, " ID"}, 3'd1, 20'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0]  rfn [3];
        logic [4:0]  ralu [3];
        logic [5:0]  iop [3];
        logic [19:0] iex [3];
        logic [5:0]  bop [4];
        logic        bz [4];
        logic        bpc [4];

        rfn = '{FN_ADD, FN_SUBU, FN_SUB};
        ralu = '{A_ADD, A_SUBU, A_SUB};
        iop = '{OP_ORI, OP_LUI, OP_SLTI};
        iex = '{ASRC | w_ext(E_ZERO) | w_alu(A_OR),
                ASRC | w_ext(E_HIGHPOS) | w_alu(A_OR),
                ASRC | w_ext(E_SIGNED) | w_alu(A_SLT)};
        bop = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        bz  = '{1'b1, 1'b0, 1'b1, 1'b0};
        bpc = '{1'b1, 1'b0, 1'b0, 1'b1};

        do_reset("init");

        // addu; IR is trashed after ID so EX must use the latched fields
        fetch_decode("addu", OP_R, FN_ADDU);
        opcode = OP_BAD;
        funct = OP_BAD;
        cyc("addu EX", 3'd2, w_alu(A_ADDU));
        cyc("addu WB", 3'd4, RW);
        cyc("addu next", 3'd0, REQ);

        // Remaining R-type ops
        for (int i = 0; i < 3; i++) begin
            fetch_decode("rtype", OP_R, rfn[i]);
            cyc("rtype EX", 3'd2, w_alu(ralu[i]));
            cyc("rtype WB", 3'd4, RW);
        end

        // Immediate ALU ops
        for (int i = 0; i < 3; i++) begin
            fetch_decode("imm", iop[i], 6'h15);
            cyc("imm EX", 3'd2, iex[i]);
            cyc("imm WB", 3'd4, RW | RDST);
        end

        // lw with three data-memory wait states: 8 cycles in total
        fetch_decode("lw", OP_LW, 6'h00);
        cyc("lw EX", 3'd2, MEM_ADDR);
        dmem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw MEM wait", 3'd3, MEM_ADDR | MR);
        dmem_rdy = 1'b1;
        cyc("lw MEM done", 3'd3, MEM_ADDR | MR);
        dmem_rdy = 1'b0;
        cyc("lw WB", 3'd4, RW | RDST | M2R);
        cyc("lw next", 3'd0, REQ);

        // Branches: pc_wr follows zero for beq, its inverse for bne
        for (int i = 0; i < 4; i++) begin
            zero = bz[i];
            fetch_decode("branch", bop[i], 6'h00);
            cyc("branch EX", 3'd2, w_pcs(2'b01) | w_alu(A_SUB) | w_ext(E_SIGNED) | (bpc[i] ? PCW : 20'h0));
            cyc("branch next", 3'd0, REQ);
        end
        zero = 1'b0;

        // j: two cycles
        opcode = OP_J;
        imem_rdy = 1'b1;
        cyc("j IF", 3'd0, FETCH);
        imem_rdy = 1'b0;
        cyc("j ID", 3'd1, PCW | w_pcs(2'b10));
        cyc("j next", 3'd0, REQ);

        // sw with zero wait: four cycles
        fetch_decode("sw", OP_SW, 6'h00);
        cyc("sw EX", 3'd2, MEM_ADDR);
        dmem_rdy = 1'b1;
        cyc("sw MEM", 3'd3, MEM_ADDR | MW);
        dmem_rdy = 1'b0;
        cyc("sw next", 3'd0, REQ);

        // Illegal opcode is sticky, no more fetch requests
        fetch_decode("bad op", OP_BAD, 6'h00);
        imem_rdy = 1'b1;
        cyc("bad op ERR", 3'd5, w_err(2'b01));
        cyc("bad op ERR held", 3'd5, w_err(2'b01));
        do_reset("bad op");

        // Unsupported R-type funct
        fetch_decode("bad fn", OP_R, 6'h00);
        cyc("bad fn ERR", 3'd5, w_err(2'b01));
        do_reset("bad fn");

        // Fetch stalls 15 cycles: timeout
        imem_rdy = 1'b0;
        for (int i = 0; i < 15; i++) cyc("if stall", 3'd0, REQ);
        imem_rdy = 1'b1;
        cyc("if timeout ERR", 3'd5, w_err(2'b10));
        do_reset("if timeout");

        // rdy rises on the 15th cycle: no error
        imem_rdy = 1'b0;
        opcode = OP_R;
        funct = FN_ADDU;
        for (int i = 0; i < 14; i++) cyc("if late", 3'd0, REQ);
        imem_rdy = 1'b1;
        cyc("if late rdy", 3'd0, FETCH);
        imem_rdy = 1'b0;
        cyc("if late ID", 3'd1, 20'h0);
        cyc("if late EX", 3'd2, w_alu(A_ADDU));
        cyc("if late WB", 3'd4, RW);

        // Data memory stalls 15 cycles on sw: timeout, no write afterwards
        fetch_decode("mem to", OP_SW, 6'h00);
        cyc("mem to EX", 3'd2, MEM_ADDR);
        for (int i = 0; i < 15; i++) cyc("mem stall", 3'd3, MEM_ADDR | MW);
        cyc("mem timeout ERR", 3'd5, w_err(2'b10));
        do_reset("mem timeout");

        // Reset asserted during sw MEM drops mem_w immediately
        fetch_decode("sw abort", OP_SW, 6'h00);
        cyc("sw abort EX", 3'd2, MEM_ADDR);
        cyc("sw abort MEM", 3'd3, MEM_ADDR | MW);
        #1 check("sw abort mem_w before", 32'(mem_w), 32'd1);
        #2;
        do_reset("sw abort");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
